// File: rtl/mem_req_arbiter.sv
// mem_req_arbiter: shares one SRAM-like master port between fetch and data.
// Define ARB_RR_EN for round-robin arbitration instead of data-first priority.
module mem_req_arbiter #(
  parameter int MAX_OUTST = 2,
  parameter int ID_PTR_W  = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata,
  output logic [2:0]  outst_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    GNT_INST,
    GNT_DATA
  } state_t;

  localparam int DEPTH = 2 ** ID_PTR_W;
  localparam logic [2:0] CNT_MAX = 3'(MAX_OUTST);
  localparam logic [ID_PTR_W-1:0] PTR_LAST = ID_PTR_W'(MAX_OUTST - 1);

  state_t state, state_nxt;
  logic fifo_q [DEPTH];
  logic [ID_PTR_W-1:0] wr_ptr, rd_ptr;
  logic [2:0] cnt;
  logic push, push_id, pop, full, head_id, pick_data;

  function automatic logic [ID_PTR_W-1:0] ptr_inc(
    input logic [ID_PTR_W-1:0] p
  );
    return (p == PTR_LAST) ? '0 : p + ID_PTR_W'(1);
  endfunction

  assign full      = (cnt == CNT_MAX);
  assign pop       = mem_data_ok && (cnt != 3'd0);
  assign head_id   = fifo_q[rd_ptr];
  assign outst_cnt = cnt;

  assign inst_data_ok = pop && !head_id;
  assign data_data_ok = pop && head_id;
  assign inst_rdata   = mem_rdata;
  assign data_rdata   = mem_rdata;

`ifdef ARB_RR_EN
  logic last_gnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      last_gnt <= 1'b0;
    end else if (push) begin
      last_gnt <= push_id;
    end
  end

  // On a tie the requester not served last wins.
  assign pick_data = data_req && (!inst_req || !last_gnt);
`else
  assign pick_data = data_req;
`endif

  always_comb begin
    state_nxt    = state;
    mem_req      = 1'b0;
    mem_wr       = 1'b0;
    mem_size     = 2'd0;
    mem_wstrb    = 4'd0;
    mem_addr     = 32'd0;
    mem_wdata    = 32'd0;
    inst_addr_ok = 1'b0;
    data_addr_ok = 1'b0;
    push         = 1'b0;
    push_id      = 1'b0;
    unique case (state)
      IDLE: begin
        if (!full && (inst_req || data_req)) begin
          state_nxt = pick_data ? GNT_DATA : GNT_INST;
        end
      end
      GNT_INST: begin
        mem_req  = 1'b1;
        mem_addr = inst_addr;
        mem_size = 2'd2;
        if (mem_addr_ok) begin
          inst_addr_ok = 1'b1;
          push         = 1'b1;
          state_nxt    = IDLE;
        end
      end
      GNT_DATA: begin
        mem_req   = 1'b1;
        mem_wr    = data_wr;
        mem_size  = data_size;
        mem_wstrb = data_wstrb;
        mem_addr  = data_addr;
        mem_wdata = data_wdata;
        push_id   = 1'b1;
        if (mem_addr_ok) begin
          data_addr_ok = 1'b1;
          push         = 1'b1;
          state_nxt    = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= 3'd0;
    end else begin
      state <= state_nxt;
      if (push) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      cnt <= cnt + {2'b00, push} - {2'b00, pop};
    end
  end

  // ID storage needs no reset: entries are only read behind a valid count.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_q[wr_ptr] <= push_id;
    end
  end

endmodule
